exception_controller: RTL and testbench

- Arbitrates exception requests from the four pipeline stages (F, D, E, M) and the external hardware interrupt lines.
- Sequences the pipeline flush and drain, then issues exactly one single-cycle exception or ERET commit to the CP0 block.
- Sits between the pipeline stage registers and CP0.
- Its commit pulse drives CP0's exception inputs (`isException`/`exceptionCause`/`exceptionPC`). CP0 then produces the PC redirect.

---
 rtl/exception_controller.sv | 155 +++++++++++++++
 tb/tb_exception_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// rtl/exception_controller.sv - exception/interrupt arbiter that flushes, drains, then commits once to CP0.
// Define EXC_CTRL_STATS_EN to add saturating exc_count/int_count commit counters.
module exception_controller #(
  parameter int         NUM_HWINT    = 6,
  parameter int         FLUSH_CYCLES = 2,
  parameter int         SYNC_STAGES  = 2,
  parameter logic [4:0] CAUSE_ERET   = 5'd31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req_valid,
  input  logic [19:0]          req_cause,
  input  logic [127:0]         req_pc,
  input  logic                 m_valid,
  input  logic [31:0]          m_pc,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic [NUM_HWINT-1:0] status_im,
  input  logic                 status_ie,
  input  logic                 status_exl,
  output logic                 cp0_exc,
  output logic [4:0]           cp0_cause,
  output logic [31:0]          cp0_pc,
  output logic [NUM_HWINT-1:0] cp0_ip,
  output logic [3:0]           flush,
  output logic                 stall,
  output logic                 busy
`ifdef EXC_CTRL_STATS_EN
  ,
  output logic [15:0]          exc_count,
  output logic [15:0]          int_count
`endif
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

  state_t               state_q;
  logic [3:0]           cnt_q;
  logic [4:0]           cap_cause_q;
  logic [31:0]          cap_pc_q;
  logic                 exc_q;
  logic [4:0]           cause_q;
  logic [31:0]          pc_q;
  logic [NUM_HWINT-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign cp0_ip = sync_q[SYNC_STAGES-1];

  logic        int_take;
  logic        event_d;
  logic [4:0]  win_cause_d;
  logic [31:0] win_pc_d;
  logic [3:0]  win_flush_d;

  assign int_take = status_ie && !status_exl && ((cp0_ip & status_im) != '0) && m_valid;

  // Ascending scan so the oldest requesting stage overwrites younger ones.
  always_comb begin
    event_d     = 1'b0;
    win_cause_d = '0;
    win_pc_d    = '0;
    win_flush_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i]) begin
        event_d     = 1'b1;
        win_cause_d = req_cause[i*5 +: 5];
        win_pc_d    = req_pc[i*32 +: 32];
        win_flush_d = 4'b1111 >> (3 - i);
      end
    end
    if (int_take) begin
      event_d     = 1'b1;
      win_cause_d = 5'd0;
      win_pc_d    = m_pc;
      win_flush_d = 4'b1111;
    end
  end

  logic accept;
  assign accept    = reset && (state_q == IDLE) && event_d;
  assign busy      = (state_q != IDLE);
  assign stall     = busy || accept;
  assign flush     = busy ? 4'b1111 : (accept ? win_flush_d : 4'b0000);
  assign cp0_exc   = exc_q;
  assign cp0_cause = cause_q;
  assign cp0_pc    = pc_q;

`ifdef EXC_CTRL_STATS_EN
  logic [15:0] exc_cnt_q;
  logic [15:0] int_cnt_q;
  assign exc_count = exc_cnt_q;
  assign int_count = int_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_cause_q <= '0;
      cap_pc_q    <= '0;
      exc_q       <= 1'b0;
      cause_q     <= '0;
      pc_q        <= '0;
`ifdef EXC_CTRL_STATS_EN
      exc_cnt_q   <= '0;
      int_cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (event_d) begin
            cap_cause_q <= win_cause_d;
            cap_pc_q    <= win_pc_d;
            cnt_q       <= 4'(FLUSH_CYCLES);
            state_q     <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt_q == 4'd1) begin
            state_q <= COMMIT;
            exc_q   <= 1'b1;
            cause_q <= cap_cause_q;
            pc_q    <= cap_pc_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          exc_q   <= 1'b0;
          cause_q <= '0;
          pc_q    <= '0;
`ifdef EXC_CTRL_STATS_EN
          if (cap_cause_q != CAUSE_ERET) begin
            if (cap_cause_q == 5'd0) begin
              if (int_cnt_q != 16'hFFFF) int_cnt_q <= int_cnt_q + 16'd1;
            end else begin
              if (exc_cnt_q != 16'hFFFF) exc_cnt_q <= exc_cnt_q + 16'd1;
            end
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_controller.sv
// tb/tb_exception_controller.sv - directed and randomized checks against a cycle-level reference model.
module tb_exception_controller;

  localparam int         NH    = 6;
  localparam int         FLUSH = 2;
  localparam int         SYNC  = 2;
  localparam logic [4:0] ERET  = 5'd31;

  logic          clk;
  logic          reset;
  logic [3:0]    req_valid;
  logic [19:0]   req_cause;
  logic [127:0]  req_pc;
  logic          m_valid;
  logic [31:0]   m_pc;
  logic [NH-1:0] hw_int;
  logic [NH-1:0] status_im;
  logic          status_ie;
  logic          status_exl;
  logic          cp0_exc;
  logic [4:0]    cp0_cause;
  logic [31:0]   cp0_pc;
  logic [NH-1:0] cp0_ip;
  logic [3:0]    flush;
  logic          stall;
  logic          busy;
`ifdef EXC_CTRL_STATS_EN
  logic [15:0]   exc_count;
  logic [15:0]   int_count;
`endif

  exception_controller #(
    .NUM_HWINT(NH), .FLUSH_CYCLES(FLUSH), .SYNC_STAGES(SYNC), .CAUSE_ERET(ERET)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_cause(req_cause),
    .req_pc(req_pc), .m_valid(m_valid), .m_pc(m_pc), .hw_int(hw_int),
    .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
    .cp0_exc(cp0_exc), .cp0_cause(cp0_cause), .cp0_pc(cp0_pc), .cp0_ip(cp0_ip),
    .flush(flush), .stall(stall), .busy(busy)
`ifdef EXC_CTRL_STATS_EN
    , .exc_count(exc_count), .int_count(int_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: a pending commit is just "the cycle it will happen on".
  int            cyc       = 0;
  int            commit_at = -1;
  bit            in_rst    = 1'b1;
  logic [4:0]    m_cause_cap;
  logic [31:0]   m_pc_cap;
  logic [NH-1:0] ipq [$];
  int            m_exc_cnt = 0;
  int            m_int_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_ipq();
    ipq = {};
    for (int i = 0; i < SYNC; i++) ipq.push_back('0);
  endtask

  task automatic tick();
    logic [NH-1:0] ip;
    logic [3:0]    e_flush;
    logic          e_stall, e_busy, e_exc, take;
    logic [4:0]    e_cause;
    logic [31:0]   e_pc;
    int            w;
    @(negedge clk);
    ip = ipq[0];
    e_flush = '0; e_stall = 0; e_busy = 0; e_exc = 0; e_cause = '0; e_pc = '0;
    if (in_rst) begin
      ip = '0;
      commit_at = -1;
    end else if (commit_at < 0) begin
      take = status_ie && !status_exl && ((ip & status_im) != 0) && m_valid;
      w = -1;
      for (int i = 3; i >= 0; i--) if (req_valid[i] && w < 0) w = i;
      if (take || w >= 0) begin
        if (take) begin
          m_cause_cap = 5'd0; m_pc_cap = m_pc; e_flush = 4'b1111;
        end else begin
          m_cause_cap = req_cause[w*5 +: 5]; m_pc_cap = req_pc[w*32 +: 32];
          e_flush = 4'((1 << (w + 1)) - 1);
        end
        e_stall = 1;
        commit_at = cyc + FLUSH + 1;
      end
    end else begin
      e_flush = 4'b1111; e_stall = 1; e_busy = 1;
      if (cyc == commit_at) begin
        e_exc = 1; e_cause = m_cause_cap; e_pc = m_pc_cap;
      end
    end
    chk("flush", 32'(flush), 32'(e_flush));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("cp0_exc", 32'(cp0_exc), 32'(e_exc));
    chk("cp0_cause", 32'(cp0_cause), 32'(e_cause));
    chk("cp0_pc", cp0_pc, e_pc);
    chk("cp0_ip", 32'(cp0_ip), 32'(ip));
`ifdef EXC_CTRL_STATS_EN
    chk("exc_count", 32'(exc_count), 32'(m_exc_cnt));
    chk("int_count", 32'(int_count), 32'(m_int_cnt));
`endif
    if (in_rst) begin
      m_exc_cnt = 0; m_int_cnt = 0;
      clear_ipq();
    end else begin
      if (e_exc) begin
        commit_at = -1;
        if (m_cause_cap != ERET) begin
          if (m_cause_cap == 5'd0) m_int_cnt = (m_int_cnt < 65535) ? m_int_cnt + 1 : 65535;
          else                     m_exc_cnt = (m_exc_cnt < 65535) ? m_exc_cnt + 1 : 65535;
        end
      end
      ipq.push_back(hw_int);
      void'(ipq.pop_front());
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 0; req_valid = 0; req_cause = 0; req_pc = 0; m_valid = 0; m_pc = 0;
    hw_int = 0; status_im = 0; status_ie = 0; status_exl = 0;
    clear_ipq();
    ticks(3);
    reset = 1; in_rst = 0;
    ticks(2);

    // E-stage exception, cause 12, pc 0x3010
    req_valid = 4'b0100; req_cause[14:10] = 5'd12; req_pc[95:64] = 32'h3010;
    tick();
    req_valid = 0;
    ticks(5);

    // Interrupt on hw_int[2]
    hw_int = 6'b000100; status_im = 6'b000100; status_ie = 1; m_valid = 1; m_pc = 32'h3040;
    ticks(6);
    hw_int = 0;
    ticks(8);

    // Simultaneous F, D, M requests: M wins
    status_ie = 0;
    req_valid = 4'b1011;
    req_cause = '0; req_cause[4:0] = 5'd4; req_cause[9:5] = 5'd10; req_cause[19:15] = 5'd5;
    req_pc = {32'h4000, 32'h3ff8, 32'h3ff4, 32'h3ff0};
    tick();
    req_valid = 0;
    ticks(5);

    // ERET under EXL with an interrupt pending, then the interrupt after EXL clears
    status_ie = 1; status_exl = 1; hw_int = 6'b000100; m_pc = 32'h5000;
    ticks(3);
    req_valid = 4'b1000; req_cause[19:15] = ERET; req_pc[127:96] = 32'h4444;
    tick();
    req_valid = 0;
    ticks(4);
    status_exl = 0;
    ticks(5);
    hw_int = 0; status_ie = 0;
    ticks(6);

    // Asynchronous reset in DRAIN
    req_valid = 4'b0100; req_cause[14:10] = 5'd9;
    tick();
    req_valid = 0;
    #2 reset = 0;
    #1;
    chk("rst_exc", 32'(cp0_exc), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    in_rst = 1;
    ticks(2);
    reset = 1; in_rst = 0;
    ticks(6);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      req_valid  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      req_cause  = 20'($urandom);
      if (req_valid[3] && $urandom_range(0, 3) == 0) req_cause[19:15] = ERET;
      req_pc     = {$urandom, $urandom, $urandom, $urandom};
      m_valid    = 1'($urandom);
      m_pc       = $urandom;
      if ($urandom_range(0, 7) == 0) hw_int = NH'($urandom);
      status_im  = NH'($urandom);
      status_ie  = 1'($urandom);
      status_exl = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
